// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted-store buffer between the core's MEM stage and a
// slow data memory. Stores queue up and drain oldest-first; loads that hit a
// queued store are forwarded combinationally, and loads that miss stall the
// core until memory returns data.
module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_write,
  input  logic          cpu_read,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_RDONE = 2'd3;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [DW-1:0] rdata_q;

  logic          full;
  logic          empty;
  logic          load_req;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic          read_miss;
  logic          accept;
  logic          drain_done;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign load_req   = cpu_read && !cpu_write;
  assign read_miss  = load_req && !hit;
  assign accept     = cpu_write && !full;
  assign drain_done = (state == ST_DRAIN) && mem_ready;

  // Scan valid entries oldest to youngest so the youngest matching store wins;
  // the entry being drained stays valid until its write completes.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_q[idx] == cpu_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  // Stall for a store into a full buffer (even if a drain finishes this cycle)
  // and for a load miss until its RDONE cycle delivers the data.
  always_comb begin
    cpu_stall = (cpu_write && full) || (read_miss && (state != ST_RDONE));
    cpu_rdata = '0;
    if (load_req) begin
      if (state == ST_RDONE) begin
        cpu_rdata = rdata_q;
      end else if (hit) begin
        cpu_rdata = hit_data;
      end
    end
  end

  // Store FIFO: enqueue at tail on accept, retire head when its write completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        addr_q[tail] <= cpu_addr;
        data_q[tail] <= cpu_wdata;
        tail         <= tail + PW'(1);
      end
      if (drain_done) begin
        head <= head + PW'(1);
      end
      case ({accept, drain_done})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Memory port sequencer; a pending read miss wins over starting a drain, but
  // never interrupts a write already in flight. Port outputs are registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (read_miss) begin
            state    <= ST_READ;
            mem_read <= 1'b1;
            mem_addr <= cpu_addr;
          end else if (!empty) begin
            state     <= ST_DRAIN;
            mem_write <= 1'b1;
            mem_addr  <= addr_q[head];
            mem_wdata <= data_q[head];
          end
        end
        ST_DRAIN: begin
          if (mem_ready) begin
            state     <= ST_IDLE;
            mem_write <= 1'b0;
          end
        end
        ST_READ: begin
          if (mem_ready) begin
            state    <= ST_RDONE;
            mem_read <= 1'b0;
            rdata_q  <= mem_rdata;
          end
        end
        ST_RDONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb_dmem_write_buffer: directed scenarios followed by randomized traffic.
// The reference is an architectural memory (every accepted store lands at
// once) plus an ordered list of stores still owed to the physical memory.
module tb_dmem_write_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } st_t;

  logic        clock;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_write;
  logic        cpu_read;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  logic [15:0] env_mem [256];
  logic [15:0] ref_mem [256];
  st_t         q [$];

  int   checks = 0;
  int   failures = 0;
  int   policy = 0;
  int   rd_wait = 0;
  int   read_wait_n = 0;
  logic order_watch = 1'b0;

  logic s_stall;
  logic [15:0] s_rdata;
  logic s_mem_write;
  logic s_mem_read;
  logic s_accepted;

  dmem_write_buffer #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_write (cpu_write),
    .cpu_read  (cpu_read),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  assign mem_rdata = mem_ready ? env_mem[mem_addr[7:0]] : 16'hDEAD;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic inQueue(input logic [15:0] a);
    foreach (q[i]) begin
      if (q[i].a == a) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock cycle: drive at posedge+1, sample and score at negedge.
  task automatic applyStimulus(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
    logic exp_full;
    st_t  front;
    cpu_write = w;
    cpu_read  = r;
    cpu_addr  = a;
    cpu_wdata = d;
    case (policy)
      0: mem_ready = 1'b0;
      1: mem_ready = 1'b1;
      2: mem_ready = 1'($urandom_range(0, 1));
      default: begin
        if (mem_read) begin
          mem_ready = (rd_wait == read_wait_n);
          rd_wait++;
        end else begin
          mem_ready = 1'b0;
          rd_wait = 0;
        end
      end
    endcase
    @(negedge clock);
    s_stall     = cpu_stall;
    s_rdata     = cpu_rdata;
    s_mem_write = mem_write;
    s_mem_read  = mem_read;
    checkOutput("wr_rd_exclusive", 32'(mem_write && mem_read), 32'd0);
    exp_full = (q.size() == DEPTH);
    if (w) checkOutput("store_stall", 32'(cpu_stall), 32'(exp_full));
    if (order_watch && mem_read) checkOutput("read_after_write", 32'(q.size()), 32'd0);
    if (mem_write && mem_ready) begin
      checkOutput("write_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        front = q.pop_front();
        checkOutput("drain_addr", 32'(mem_addr), 32'(front.a));
        checkOutput("drain_data", 32'(mem_wdata), 32'(front.d));
      end
      env_mem[mem_addr[7:0]] = mem_wdata;
    end
    s_accepted = w && !exp_full;
    if (s_accepted) begin
      q.push_back({a, d});
      ref_mem[a[7:0]] = d;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic doStore(input logic [15:0] a, input logic [15:0] d, input logic r);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      applyStimulus(1'b1, r, a, d);
      if (r) checkOutput("wr_rd_rdata_zero", 32'(s_rdata), 32'd0);
      done = s_accepted;
    end
    checkOutput("store_timeout", 32'(done), 32'd1);
  endtask

  task automatic doLoad(input logic [15:0] a, input logic exp_first_stall, output int stall_cycles);
    logic        done;
    logic [15:0] exp;
    done = 1'b0;
    stall_cycles = 0;
    exp = ref_mem[a[7:0]];
    for (int k = 0; k < 60 && !done; k++) begin
      applyStimulus(1'b0, 1'b1, a, 16'h0000);
      if (k == 0) checkOutput("load_first_stall", 32'(s_stall), 32'(exp_first_stall));
      if (s_stall) begin
        stall_cycles++;
      end else begin
        done = 1'b1;
        checkOutput("load_data", 32'(s_rdata), 32'(exp));
      end
    end
    checkOutput("load_timeout", 32'(done), 32'd1);
  endtask

  task automatic drainAll();
    policy = 1;
    for (int k = 0; k < 60 && q.size() != 0; k++) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("drain_empty", 32'(q.size()), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    checkOutput({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    checkOutput({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd0);
    checkOutput({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
  endtask

  initial begin
    int          sc;
    int          op;
    logic [15:0] a;
    logic [15:0] d;

    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    env_mem[8'h40] = 16'h5A5A; ref_mem[8'h40] = 16'h5A5A;
    env_mem[8'h60] = 16'h6666; ref_mem[8'h60] = 16'h6666;

    cpu_write = 1'b0; cpu_read = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkZeroOutputs("reset");
    reset = 1'b0;

    $display("[TB] scenario 1: three posted stores drain in order");
    policy = 1;
    doStore(16'h0010, 16'h1111, 1'b0);
    doStore(16'h0012, 16'h2222, 1'b0);
    doStore(16'h0014, 16'h3333, 1'b0);
    drainAll();

    $display("[TB] scenario 2: youngest queued store forwarded");
    policy = 0;
    doStore(16'h0020, 16'hAAAA, 1'b0);
    doStore(16'h0020, 16'hBBBB, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0020, 16'h0);
    checkOutput("fwd_stall", 32'(s_stall), 32'd0);
    checkOutput("fwd_rdata", 32'(s_rdata), 32'h0000BBBB);
    drainAll();

    $display("[TB] scenario 3: full buffer stalls a store");
    policy = 0;
    for (int i = 0; i < DEPTH; i++) doStore(16'h0030 + 16'(2 * i), 16'hC000 + 16'(i), 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0038, 16'hC004);
    checkOutput("full_stall", 32'(s_stall), 32'd1);
    policy = 1;
    applyStimulus(1'b1, 1'b0, 16'h0038, 16'hC004);
    checkOutput("full_stall_while_drain", 32'(s_stall), 32'd1);
    policy = 0;
    applyStimulus(1'b1, 1'b0, 16'h0038, 16'hC004);
    checkOutput("full_accept_after_drain", 32'(s_stall), 32'd0);
    drainAll();

    $display("[TB] scenario 4: load miss with three memory wait cycles");
    policy = 3; read_wait_n = 3; rd_wait = 0;
    doLoad(16'h0040, 1'b1, sc);
    checkOutput("miss_stall_cycles", 32'(sc), 32'd5);
    checkOutput("miss_mem_read_off", 32'(s_mem_read), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0040, 16'h0);
    checkOutput("idle_rdata_zero", 32'(s_rdata), 32'd0);

    $display("[TB] scenario 5: load miss waits for in-flight write");
    policy = 0;
    doStore(16'h0050, 16'h7777, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    order_watch = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h0060, 16'h0);
      checkOutput("inflight_stall", 32'(s_stall), 32'd1);
      checkOutput("inflight_mem_write", 32'(s_mem_write), 32'd1);
      checkOutput("inflight_mem_read", 32'(s_mem_read), 32'd0);
    end
    policy = 1;
    doLoad(16'h0060, 1'b1, sc);
    order_watch = 1'b0;
    checkOutput("inflight_drained", 32'(q.size()), 32'd0);

    $display("[TB] scenario 6: reset during a drain");
    policy = 0;
    doStore(16'h0070, 16'h1234, 1'b0);
    doStore(16'h0072, 16'h5678, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    checkOutput("drain_active", 32'(s_mem_write), 32'd1);
    #2 reset = 1'b1;
    #1 checkZeroOutputs("async_reset");
    @(posedge clock);
    #1 reset = 1'b0;
    q.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = env_mem[i];
    policy = 1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput("no_write_after_reset", 32'(s_mem_write), 32'd0);
    end

    $display("[TB] random traffic");
    policy = 2;
    for (int n = 0; n < 200; n++) begin
      op = int'($urandom_range(0, 9));
      a  = 16'h0080 + 16'(2 * $urandom_range(0, 15));
      d  = 16'($urandom);
      if (op < 5) begin
        doStore(a, d, ($urandom_range(0, 7) == 0));
      end else if (op < 9) begin
        doLoad(a, !inQueue(a), sc);
      end else begin
        applyStimulus(1'b0, 1'b0, a, d);
        checkOutput("rand_idle_rdata", 32'(s_rdata), 32'd0);
      end
    end
    drainAll();
    for (int i = 0; i < 16; i++) begin
      checkOutput("final_mem", 32'(env_mem[8'h80 + 8'(2 * i)]), 32'(ref_mem[8'h80 + 8'(2 * i)]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
